// File: rtl/mon_pkg.sv
// mon_pkg: shared constants and types for the instruction monitor event scheduler.
//   - opcode constants for the classifier
//   - event kind codes carried in each FIFO entry
//   - FSM state encoding
//   - classify(): maps an instruction word to an event kind (KIND_NONE = no event)
package mon_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_R    = 2'b01;
  localparam logic [1:0] KIND_J    = 2'b10;
  localparam logic [1:0] KIND_JAL  = 2'b11;

  // One FIFO entry: {kind[1:0], pc[31:0]}
  localparam int EV_W = 34;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_e;

  // The all-zero word is the canonical NOP; it shares the R-type opcode but is
  // never reported as an event.
  function automatic logic [1:0] classify(input logic [31:0] inst);
    logic [1:0] kind;
    case (inst[31:26])
      OP_RTYPE: begin
        if (inst == 32'h0000_0000) begin
          kind = KIND_NONE;
        end else begin
          kind = KIND_R;
        end
      end
      OP_J:    kind = KIND_J;
      OP_JAL:  kind = KIND_JAL;
      default: kind = KIND_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/mon_event_fifo.sv
// mon_event_fifo: synchronous FIFO for monitor events.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push/wdata : write request and data; ignored when full unless a pop occurs
//                in the same cycle
//   pop        : read request; ignored when empty
//   rdata      : head entry, forced to zero while empty
//   full/empty : status flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module mon_event_fifo
  import mon_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = EV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/mon_event_sched.sv
// mon_event_sched: instruction monitor event scheduler.
//   clk, rst           : clock, synchronous active-high reset
//   en                 : monitor enable (IDLE -> RUN, RUN -> DRAIN on drop)
//   in_valid, pc, inst : retired instruction stream
//   r, j               : registered one-cycle pulses for captured R-type / J-JAL
//   ev_valid/ev_ready  : event handshake to the consumer
//   ev_kind, ev_pc     : head event (zero while empty)
//   busy               : FSM not in IDLE
//   drop_cnt           : saturating count of events lost to overflow
// Build option: define MON_DROP_CNT_EN to instantiate the drop counter;
// otherwise drop_cnt is tied to zero and overflowed events vanish silently.
module mon_event_sched
  import mon_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [31:0]      pc,
  input  logic [31:0]      inst,
  output logic             r,
  output logic             j,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [1:0]       ev_kind,
  output logic [31:0]      ev_pc,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  state_e          state_q, state_d;
  logic [1:0]      kind_s;
  logic            capture_s;
  logic            pop_s;
  logic            drop_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [EV_W-1:0] head_s;
  logic            r_q, r_d;
  logic            j_q, j_d;

  assign kind_s    = classify(inst);
  assign capture_s = (state_q == RUN) && in_valid && (kind_s != KIND_NONE);
  assign pop_s     = ev_valid && ev_ready;
  assign drop_s    = capture_s && fifo_full_s && !pop_s;

  mon_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture_s),
    .pop   (pop_s),
    .wdata ({kind_s, pc}),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign ev_valid = !fifo_empty_s;
  assign ev_kind  = head_s[33:32];
  assign ev_pc    = head_s[31:0];
  assign busy     = (state_q != IDLE);
  assign r        = r_q;
  assign j        = j_q;

  // Next state and capture pulses
  always_comb begin
    state_d = state_q;
    r_d     = capture_s && (kind_s == KIND_R);
    j_d     = capture_s && ((kind_s == KIND_J) || (kind_s == KIND_JAL));
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (en) begin
          state_d = RUN;
        end else if (fifo_empty_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= 1'b0;
      j_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      j_q     <= j_d;
    end
  end

`ifdef MON_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating increment on each dropped event
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= {CNT_W{1'b0}};
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop_s;
  assign unused_drop_s = drop_s;
  assign drop_cnt      = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/mon_event_sched.md
# mon_event_sched

Event scheduler for the instruction monitor. Samples the retired pc/inst stream, classifies R-type and jump instructions, and buffers each event ({kind, pc}) in a small FIFO. Events drain to a downstream consumer (logger / policy checker) over a valid/ready handshake. Also sequences monitor enable/drain and flags events lost to overflow.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2
- `CNT_W`, 16: drop-counter width
- `clk` input 1: clock
- `rst` input 1: synchronous active-high reset
- `en` input 1: monitor enable
- `in_valid` input 1: pc/inst pair valid this cycle
- `pc` input 32: program counter of the instruction
- `inst` input 32: instruction word
- `r` output 1: registered pulse, R-type event captured
- `j` output 1: registered pulse, J/JAL event captured
- `ev_valid` output 1: FIFO head valid
- `ev_ready` input 1: consumer accepts head
- `ev_kind` output 2: head kind; 01 R-type, 10 J, 11 JAL
- `ev_pc` output 32: head pc
- `busy` output 1: FSM not IDLE
- `drop_cnt` output CNT_W: saturating count of dropped events

## Operation
- Opcode = `inst[31:26]`:
  - 6'h00 → R-type, except `inst == 0` (NOP), which is never an event.
  - 6'h02 → J; 6'h03 → JAL; all other opcodes → no event.
- Capture occurs only when state == RUN and `in_valid` = 1 and the instruction classifies as an event.
- FSM states:
  - IDLE: no capture. `en` = 1 → RUN.
  - RUN: capture. `en` = 0 → DRAIN.
  - DRAIN: no capture; FIFO keeps draining. `en` = 1 → RUN; `en` = 0 and FIFO empty → IDLE.
- `busy` = (state != IDLE).
- FIFO:
  - Push = capture; pop = `ev_valid & ev_ready`.
  - Full with push and no pop → event dropped, `drop_cnt` += 1, saturating at all-ones.
  - Full with simultaneous push and pop → both occur, no drop.
  - Empty → `ev_valid` = 0; `ev_kind`/`ev_pc` are don't-care.
  - Pointers are log2(DEPTH)+1 bits wide; wrap-around is natural.
- `r`/`j` pulse for every classified event in RUN, including events that are dropped.
- Reset values: state IDLE; FIFO empty; `r`, `j`, `ev_valid`, `busy` = 0; `ev_kind` = 0; `ev_pc` = 0; `drop_cnt` = 0.
- Reset mid-operation discards all buffered events.

## Timing
- Inputs are sampled on rising edge N.
- `r`/`j` are high for exactly cycle N+1.
- An event pushed at edge N is visible on `ev_valid`/`ev_pc` in cycle N+1 if the FIFO was empty (1-cycle latency).
- `en` rising at edge N: state becomes RUN after N. An `in_valid` coincident with that `en` rise is not captured; capture starts at edge N+1.
- `en` falling: the last capture is the edge where state was still RUN.
- Pop at edge N: the next head is presented in cycle N+1; no bubble with back-to-back `ev_ready`.
- Sustained throughput: one event per cycle in and out.

## Configuration
- `MON_DROP_CNT_EN`:
  - Defined: counter logic instantiated as above.
  - Undefined: `drop_cnt` tied to 0 and no counter flops. Overflow still drops the event silently.

## Structure
- Package `mon_pkg`:
  - opcode constants `OP_RTYPE`=6'h00, `OP_J`=6'h02, `OP_JAL`=6'h03
  - kind codes `KIND_R`=2'b01, `KIND_J`=2'b10, `KIND_JAL`=2'b11
  - FSM state encoding IDLE/RUN/DRAIN
- Sub-module `mon_event_fifo`: parameterised synchronous FIFO (DEPTH, width 34) with push/pop/full/empty.
- Top-level holds the classifier, FSM, pulses and drop counter.

## Test plan
- Reset, `en`=1, `ev_ready`=1; `in_valid` with pc=0x0C000000, inst=0x0C000001 → `j` pulse next cycle; `ev_kind`=11, `ev_pc`=0x0C000000.
- inst=0x00000000 then inst=0x00184008 at pc=0x3C000000 → NOP gives no event; second gives `r` pulse, `ev_kind`=01, `ev_pc`=0x3C000000.
- inst=0x4080410C (opcode 0x10) → no pulse, `ev_valid` stays 0.
- `ev_ready`=0, six back-to-back R-type events with DEPTH=4 → 4 buffered, `drop_cnt`=2 with macro, 0 without. Next push with simultaneous pop → no further drop.
- Two events buffered, then `en`=0 → state DRAIN, `busy`=1; new inputs ignored. After 2 pops → IDLE, `busy`=0 one cycle after FIFO empties.
- Assert `rst` with 3 events queued → next cycle `ev_valid`=0, `drop_cnt`=0, `busy`=0.
